test_wr_ctrl_128bit: RTL and testbench

- Self-test AXI write initiator for the DDR3 example design, 128-bit AXI data path. It is the write-side partner of the read-check controller.
- Issues one INCR burst per request using the random address, ID and length supplied by the test sequencer.
- Generates per-lane self-checking data, in which each 16-bit lane is {rnd, rnd ^ lane_addr}, or a fixed 0/1 pattern.
- Accepts the B response and emits a done pulse.

---
 rtl/test_ddr_pkg.sv | 45 ++++
 rtl/test_wr_data_gen.sv | 48 ++++
 rtl/test_wr_ctrl_128bit.sv | 164 ++++++++++++++++
 tb/tb_test_wr_ctrl_128bit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_ddr_pkg.sv
// Shared definitions for the DDR3 self-test AXI initiators: FSM encoding,
// AXI constants, LFSR seed/taps, lane count and small data helpers.
package test_ddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_END  = 3'd4
  } wr_state_e;

  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 -> register bits 7, 5, 4, 3 feed back
  localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

  localparam int LANE_CNT = 8;

  // One Fibonacci step: shift left, feedback enters at bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Rotate an 8-bit value left by amt (0..7)
  function automatic logic [7:0] rotl8(input logic [7:0] val, input logic [2:0] amt);
    logic [15:0] dbl;
    dbl = {val, val} << amt;
    return dbl[15:8];
  endfunction

  // Self-checking 16-bit lane word: {rnd, rnd ^ lane address}
  function automatic logic [15:0] lane_word(input logic [7:0] lfsr, input logic [7:0] lane_base,
                                            input logic [2:0] lane);
    logic [7:0] rnd;
    logic [7:0] lane_addr;
    rnd       = rotl8(lfsr, lane);
    lane_addr = lane_base + {5'b00000, lane};
    return {rnd, rnd ^ lane_addr};
  endfunction

endpackage

// File: rtl/test_wr_data_gen.sv
// Write data generator: owns the LFSR and the per-beat lane base address and
// builds the wide write word combinationally from those registers.
module test_wr_data_gen
  import test_ddr_pkg::*;
#(
  parameter int MEM_DQ_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [7:0]                       base,
  input  logic                             advance,
  input  logic                             pattern,
  output logic [LANE_CNT*MEM_DQ_WIDTH-1:0] wdata
);

  logic [7:0] lfsr;
  logic [7:0] lane_base;

  // LFSR and lane base move together on every accepted write beat
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= LFSR_SEED;
      lane_base <= 8'h00;
    end else begin
      if (advance) lfsr <= lfsr_step(lfsr);
      else         lfsr <= lfsr;
      if (load)         lane_base <= base;
      else if (advance) lane_base <= lane_base + 8'd8;
      else              lane_base <= lane_base;
    end
  end

  // Per-lane data: fixed 0/1 stripes or address-keyed pseudo-random words
  always_comb begin
    wdata = '0;
    for (int k = 0; k < LANE_CNT; k++) begin
      if (pattern) begin
        if (k[0]) wdata[k*MEM_DQ_WIDTH +: MEM_DQ_WIDTH] = {MEM_DQ_WIDTH{1'b1}};
        else      wdata[k*MEM_DQ_WIDTH +: MEM_DQ_WIDTH] = {MEM_DQ_WIDTH{1'b0}};
      end else begin
        wdata[k*MEM_DQ_WIDTH +: MEM_DQ_WIDTH] =
          {(MEM_DQ_WIDTH/16){lane_word(lfsr, lane_base, k[2:0])}};
      end
    end
  end

endmodule

// File: rtl/test_wr_ctrl_128bit.sv
// Self-test AXI write initiator (128-bit data path). Issues one INCR burst per
// request, streams self-checking data and pulses write_done_p on the B response.
// Optional macro TEST_WR_BRESP_CHK_EN enables counting of non-OKAY responses.
module test_wr_ctrl_128bit
  import test_ddr_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH    = 28,
  parameter int MEM_DQ_WIDTH       = 16,
  parameter int MEM_COL_ADDR_WIDTH = 10,
  parameter int MEM_SPACE_AW       = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       write_en,
  input  logic                       data_pattern_01,
  output logic                       write_done_p,
  output logic [31:0]                axi_awaddr,
  output logic [7:0]                 axi_awid,
  output logic [7:0]                 axi_awlen,
  output logic [2:0]                 axi_awsize,
  output logic [1:0]                 axi_awburst,
  output logic                       axi_awlock,
  output logic                       axi_awurgent,
  output logic                       axi_awpoison,
  output logic [3:0]                 axi_awqos,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [127:0]               axi_wdata,
  output logic [15:0]                axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  input  logic [7:0]                 axi_bid,
  input  logic [1:0]                 axi_bresp,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  output logic [7:0]                 bresp_err_cnt,
  output logic                       bresp_err_flag
);

  // Geometry parameters kept for interface compatibility only
  localparam int unused_geometry = MEM_COL_ADDR_WIDTH + MEM_SPACE_AW;

  wr_state_e  state;
  wr_state_e  state_nxt;
  logic [7:0] beat_cnt;
  logic       start;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       awvalid_nxt;
  logic       wvalid_nxt;
  logic       bready_nxt;
  logic       done_nxt;
  logic [LANE_CNT*MEM_DQ_WIDTH-1:0] gen_data;
  logic       unused_inputs;

  assign start = (state == S_IDLE) && write_en;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign b_hs  = axi_bvalid && axi_bready;

  assign axi_awsize    = SIZE_16B;
  assign axi_awburst   = BURST_INCR;
  assign axi_awlock    = 1'b0;
  assign axi_awurgent  = 1'b0;
  assign axi_awpoison  = 1'b0;
  assign axi_awqos     = 4'h0;
  assign axi_wstrb     = 16'hFFFF;
  assign axi_wlast     = axi_wvalid && (beat_cnt == axi_awlen);
  assign axi_wdata     = axi_wvalid ? gen_data : '0;
  assign unused_inputs = ^{axi_bid, axi_bresp};

  test_wr_data_gen #(
    .MEM_DQ_WIDTH (MEM_DQ_WIDTH)
  ) u_data_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .base    (random_rw_addr[7:0]),
    .advance (w_hs),
    .pattern (data_pattern_01),
    .wdata   (gen_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one burst outstanding at a time
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (write_en) state_nxt = S_AW; else state_nxt = S_IDLE;
      S_AW:   if (aw_hs) state_nxt = S_W; else state_nxt = S_AW;
      S_W:    if (w_hs && axi_wlast) state_nxt = S_B; else state_nxt = S_W;
      S_B:    if (b_hs) state_nxt = S_END; else state_nxt = S_B;
      S_END:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake outputs come straight from flops
  always_comb begin
    awvalid_nxt = (state_nxt == S_AW);
    wvalid_nxt  = (state_nxt == S_W);
    bready_nxt  = (state_nxt == S_B);
    done_nxt    = (state == S_B) && b_hs;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_awvalid  <= 1'b0;
      axi_wvalid   <= 1'b0;
      axi_bready   <= 1'b0;
      write_done_p <= 1'b0;
    end else begin
      axi_awvalid  <= awvalid_nxt;
      axi_wvalid   <= wvalid_nxt;
      axi_bready   <= bready_nxt;
      write_done_p <= done_nxt;
    end
  end

  // Burst attributes latched at request time, beat counter per accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_awaddr <= 32'h0000_0000;
      axi_awid   <= 8'h00;
      axi_awlen  <= 8'h00;
      beat_cnt   <= 8'h00;
    end else if (start) begin
      axi_awaddr <= {{(31-CTRL_ADDR_WIDTH){1'b0}}, random_rw_addr, 1'b0};
      axi_awid   <= {4'h0, random_axi_id};
      axi_awlen  <= {4'h0, random_axi_len};
      beat_cnt   <= 8'h00;
    end else if (w_hs) begin
      beat_cnt   <= beat_cnt + 8'd1;
    end
  end

`ifdef TEST_WR_BRESP_CHK_EN
  // Saturating count and sticky flag for non-OKAY write responses
  always_ff @(posedge clk) begin
    if (rst) begin
      bresp_err_cnt  <= 8'h00;
      bresp_err_flag <= 1'b0;
    end else if ((state == S_B) && b_hs && (axi_bresp != RESP_OKAY)) begin
      if (bresp_err_cnt != 8'hFF) bresp_err_cnt <= bresp_err_cnt + 8'd1;
      bresp_err_flag <= 1'b1;
    end
  end
`else
  assign bresp_err_cnt  = 8'h00;
  assign bresp_err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_test_wr_ctrl_128bit.sv
// Self-checking bench for test_wr_ctrl_128bit: randomized bursts compared
// against a behavioural model of the LFSR, lane data and response counter.
`timescale 1ns/1ps
module tb_test_wr_ctrl_128bit;

  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  random_rw_addr;
  logic [3:0]   random_axi_id;
  logic [3:0]   random_axi_len;
  logic         write_en;
  logic         data_pattern_01;
  logic         write_done_p;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awid;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awlock;
  logic         axi_awurgent;
  logic         axi_awpoison;
  logic [3:0]   axi_awqos;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [127:0] axi_wdata;
  logic [15:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [7:0]   axi_bid;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic [7:0]   bresp_err_cnt;
  logic         bresp_err_flag;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;
  int n_bad;

  always #5 clk = ~clk;

  test_wr_ctrl_128bit dut (
    .clk(clk), .rst(rst),
    .random_rw_addr(random_rw_addr), .random_axi_id(random_axi_id),
    .random_axi_len(random_axi_len), .write_en(write_en),
    .data_pattern_01(data_pattern_01), .write_done_p(write_done_p),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awurgent(axi_awurgent), .axi_awpoison(axi_awpoison), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .bresp_err_cnt(bresp_err_cnt), .bresp_err_flag(bresp_err_flag)
  );

  // Polynomial x^8+x^6+x^5+x^4+1: new bit 0 is parity of bits 7,5,4,3
  function automatic logic [7:0] model_step(input logic [7:0] s);
    int v, fb;
    v  = int'(s);
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return 8'(((v << 1) | fb) & 255);
  endfunction

  function automatic logic [127:0] model_data(input logic [7:0] lf, input logic [7:0] base,
                                              input logic pat);
    logic [127:0] d;
    int v, rnd, a;
    d = '0;
    v = int'(lf);
    for (int k = 0; k < 8; k++) begin
      if (pat) begin
        if (k % 2 == 1) d[k*16 +: 16] = 16'hFFFF;
        else            d[k*16 +: 16] = 16'h0000;
      end else begin
        rnd = ((v << k) | (v >> (8 - k))) & 255;
        a   = (int'(base) + k) % 256;
        d[k*16 +: 16] = 16'((rnd << 8) | (rnd ^ a));
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] exp_err_cnt();
`ifdef TEST_WR_BRESP_CHK_EN
    return (n_bad > 255) ? 8'hFF : 8'(n_bad);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic exp_err_flag();
`ifdef TEST_WR_BRESP_CHK_EN
    return (n_bad > 0);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one complete burst and check every channel cycle by cycle
  task automatic run_burst(input logic [27:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic pat, input int aw_stall, input int w_mode,
                           input logic [1:0] resp);
    int ph, waited, beat;
    logic tog;
    logic [7:0] base;
    logic [31:0] exp_addr;
    logic [127:0] exp_wd;
    random_rw_addr  = addr;
    random_axi_id   = id;
    random_axi_len  = len;
    data_pattern_01 = pat;
    axi_bresp       = resp;
    axi_bid         = 8'($urandom);
    axi_awready     = 1'b0;
    axi_wready      = 1'b0;
    axi_bvalid      = 1'b0;
    write_en        = 1'b1;
    exp_addr = {3'b000, addr, 1'b0};
    ph = 0; waited = 0; beat = 0; tog = 1'b0;
    @(posedge clk); #1;
    write_en = 1'b0;
    for (int cyc = 0; cyc < 400 && ph < 5; cyc++) begin
      case (ph)
        0: begin
          checks++;
          if (axi_awvalid !== 1'b1 || axi_awaddr !== exp_addr || axi_awid !== {4'h0, id} ||
              axi_awlen !== {4'h0, len} || axi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_phase: got valid=%b addr=%h id=%h len=%h wvalid=%b, want 1 %h %h %h 0",
                     axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_wvalid,
                     exp_addr, {4'h0, id}, {4'h0, len});
          end
          checks++;
          if (axi_awsize !== 3'b100 || axi_awburst !== 2'b01 || axi_awlock !== 1'b0 ||
              axi_awurgent !== 1'b0 || axi_awpoison !== 1'b0 || axi_awqos !== 4'h0 ||
              axi_wstrb !== 16'hFFFF) begin
            errors++;
            $display("FAIL aw_consts: got size=%b burst=%b lock=%b urg=%b poi=%b qos=%h strb=%h, want 100 01 0 0 0 0 ffff",
                     axi_awsize, axi_awburst, axi_awlock, axi_awurgent, axi_awpoison,
                     axi_awqos, axi_wstrb);
          end
          if (waited < aw_stall) begin axi_awready = 1'b0; waited++; end
          else begin axi_awready = 1'b1; ph = 1; end
        end
        1: begin
          axi_awready = 1'b0;
          base   = addr[7:0] + 8'(beat * 8);
          exp_wd = model_data(m_lfsr, base, pat);
          checks++;
          if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b1 || axi_wdata !== exp_wd ||
              axi_wlast !== (beat == int'(len))) begin
            errors++;
            $display("FAIL w_beat%0d: got awv=%b wv=%b last=%b data=%h, want 0 1 %b %h",
                     beat, axi_awvalid, axi_wvalid, axi_wlast, axi_wdata,
                     (beat == int'(len)), exp_wd);
          end
          case (w_mode)
            0: axi_wready = 1'b1;
            1: begin tog = ~tog; axi_wready = tog; end
            default: axi_wready = 1'($urandom_range(0, 1));
          endcase
          if (axi_wready) begin
            m_lfsr = model_step(m_lfsr);
            beat++;
            if (beat > int'(len)) ph = 2;
          end
        end
        2: begin
          axi_wready = 1'b0;
          checks++;
          if (axi_wvalid !== 1'b0 || axi_bready !== 1'b1 || write_done_p !== 1'b0) begin
            errors++;
            $display("FAIL b_wait: got wvalid=%b bready=%b done=%b, want 0 1 0",
                     axi_wvalid, axi_bready, write_done_p);
          end
          axi_bvalid = 1'b1;
          ph = 3;
        end
        3: begin
          axi_bvalid = 1'b0;
          if (resp != 2'b00) n_bad++;
          checks++;
          if (write_done_p !== 1'b1 || axi_bready !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b bready=%b, want 1 0", write_done_p, axi_bready);
          end
          ph = 4;
        end
        default: begin
          checks++;
          if (write_done_p !== 1'b0 || axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL done_single: got done=%b awvalid=%b, want 0 0", write_done_p, axi_awvalid);
          end
          ph = 5;
        end
      endcase
      if (ph < 5) begin @(posedge clk); #1; end
    end
    if (ph < 5) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got phase %0d, want 5", ph);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; write_en = 1'b0; data_pattern_01 = 1'b0;
    random_rw_addr = 28'h0; random_axi_id = 4'h0; random_axi_len = 4'h0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    axi_bid = 8'h00; axi_bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = 8'hA5; n_bad = 0;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready, write_done_p, axi_wlast} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_valids: got %b, want 00000",
               {axi_awvalid, axi_wvalid, axi_bready, write_done_p, axi_wlast});
    end
    checks++;
    if (axi_awaddr !== 32'h0 || axi_awid !== 8'h0 || axi_awlen !== 8'h0 || axi_wdata !== 128'h0 ||
        bresp_err_cnt !== 8'h00 || bresp_err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h id=%h len=%h data=%h cnt=%h flag=%b, want zeros",
               axi_awaddr, axi_awid, axi_awlen, axi_wdata, bresp_err_cnt, bresp_err_flag);
    end
    @(posedge clk); #1;
    checks++;
    if (axi_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got awvalid=%b, want 0", axi_awvalid);
    end
  endtask

  task automatic test_basic();
    run_burst(28'h0000010, 4'd3, 4'd0, 1'b0, 0, 0, 2'b00);
  endtask

  task automatic test_aw_stall();
    run_burst(28'h0000010, 4'd5, 4'd15, 1'b0, 5, 0, 2'b00);
  endtask

  task automatic test_wready_toggle();
    run_burst(28'($urandom), 4'($urandom), 4'd15, 1'b0, 0, 1, 2'b00);
  endtask

  task automatic test_pattern();
    run_burst(28'($urandom), 4'($urandom), 4'd3, 1'b1, 1, 2, 2'b00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_burst(28'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 2'b00);
  endtask

  task automatic test_bresp();
    run_burst(28'($urandom), 4'($urandom), 4'd0, 1'b0, 0, 0, 2'b10);
    checks++;
    if (bresp_err_cnt !== exp_err_cnt() || bresp_err_flag !== exp_err_flag()) begin
      errors++;
      $display("FAIL bresp_first: got cnt=%h flag=%b, want %h %b",
               bresp_err_cnt, bresp_err_flag, exp_err_cnt(), exp_err_flag());
    end
    for (int i = 0; i < 299; i++)
      run_burst(28'($urandom), 4'($urandom), 4'd0, 1'b0, 0, 0, 2'($urandom_range(1, 3)));
    run_burst(28'($urandom), 4'($urandom), 4'd1, 1'b0, 0, 0, 2'b00);
    checks++;
    if (bresp_err_cnt !== exp_err_cnt() || bresp_err_flag !== exp_err_flag()) begin
      errors++;
      $display("FAIL bresp_saturate: got cnt=%h flag=%b, want %h %b",
               bresp_err_cnt, bresp_err_flag, exp_err_cnt(), exp_err_flag());
    end
  endtask

  task automatic test_reset_mid_burst();
    random_rw_addr = 28'($urandom); random_axi_id = 4'($urandom); random_axi_len = 4'd15;
    data_pattern_01 = 1'b0; axi_awready = 1'b1; axi_wready = 1'b0; axi_bvalid = 1'b0;
    write_en = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0;
    @(posedge clk); #1;
    axi_awready = 1'b0;
    checks++;
    if (axi_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_enter_w: got wvalid=%b, want 1", axi_wvalid);
    end
    axi_wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b0) begin
      errors++;
      $display("FAIL mid_beat4: got wvalid=%b wlast=%b, want 1 0", axi_wvalid, axi_wlast);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; axi_wready = 1'b0;
    m_lfsr = 8'hA5; n_bad = 0;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready, write_done_p, axi_wlast} !== 5'b00000 ||
        bresp_err_cnt !== 8'h00 || bresp_err_flag !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valids=%b cnt=%h flag=%b, want 00000 00 0",
               {axi_awvalid, axi_wvalid, axi_bready, write_done_p, axi_wlast},
               bresp_err_cnt, bresp_err_flag);
    end
    @(posedge clk); #1;
    checks++;
    if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got awvalid=%b wvalid=%b, want 0 0", axi_awvalid, axi_wvalid);
    end
    run_burst(28'($urandom), 4'($urandom), 4'd7, 1'b0, 1, 2, 2'b00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_stall();
    test_wready_toggle();
    test_pattern();
    test_random();
    test_bresp();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
